irq_vector_ctrl: RTL and testbench

//  Parametrised interrupt front-end for the CPU core: replaces the single nmi/irq pins with NMI plus
//  NUM_IRQ maskable channels. Each channel is edge- or level-sensitive; per-channel vectors are optional.

---
 rtl/irq_pkg.sv | 22 ++
 rtl/irq_vector_ctrl_if.sv | 32 +++
 rtl/irq_edge_latch.sv | 41 ++++
 rtl/irq_vector_ctrl.sv | 158 +++++++++++++++
 tb/tb_irq_vector_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
//------------------------------------------------------------------------------
// Module : irq_pkg
// Brief  : Shared vector constants and FSM state encoding for irq_vector_ctrl.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package irq_pkg;

    localparam logic [15:0] VEC_NMI   = 16'hFFFA;
    localparam logic [15:0] VEC_RESET = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        LO_DONE = 2'd2
    } irq_state_e;

endpackage

`default_nettype wire

// File: rtl/irq_vector_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : irq_vector_ctrl_if
// Brief  : CPU-side handshake between the core and the interrupt front-end.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface irq_vector_ctrl_if;

    logic        sample;
    logic        vec_fetch;
    logic        vec_hi;
    logic        i_flag;
    logic        take_int;
    logic        is_reset;
    logic        is_nmi;
    logic [2:0]  int_id;
    logic [15:0] vec_addr;

    modport master (
        output sample, vec_fetch, vec_hi, i_flag,
        input  take_int, is_reset, is_nmi, int_id, vec_addr
    );

    modport slave (
        input  sample, vec_fetch, vec_hi, i_flag,
        output take_int, is_reset, is_nmi, int_id, vec_addr
    );

endinterface

`default_nettype wire

// File: rtl/irq_edge_latch.sv
//------------------------------------------------------------------------------
// Module : irq_edge_latch
// Brief  : Rising-edge detector with freeze and a set-over-clear sticky latch.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module irq_edge_latch (
    input  wire logic clk,
    input  wire logic ce,
    input  wire logic reset,
    input  wire logic din,
    input  wire logic freeze,
    input  wire logic clr,
    output logic      latch
);

    logic r_last;
    logic r_latch;
    logic w_rise;

    // While frozen the history is held too, so an edge during the freeze is seen afterwards.
    assign w_rise = din & ~r_last & ~freeze;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last  <= 1'b0;
            r_latch <= 1'b0;
        end else if (ce) begin
            if (!freeze) begin
                r_last <= din;
            end
            r_latch <= w_rise | (r_latch & ~clr);
        end
    end

    assign latch = r_latch;

endmodule

`default_nettype wire

// File: rtl/irq_vector_ctrl.sv
//------------------------------------------------------------------------------
// Module : irq_vector_ctrl
// Brief  : NMI + NUM_IRQ channel interrupt front-end with vector tracking/ack.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module irq_vector_ctrl
    import irq_pkg::*;
#(
    parameter int          NUM_IRQ      = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
    parameter int          VECTORED     = 0,
    parameter logic [15:0] IRQ_TBL_BASE = 16'hFFE0
) (
    input  wire logic               clk,
    input  wire logic               ce,
    input  wire logic               reset,
    input  wire logic               nmi,
    input  wire logic [NUM_IRQ-1:0] irq,
    input  wire logic [NUM_IRQ-1:0] irq_en,
    output logic      [NUM_IRQ-1:0] pending,
    irq_vector_ctrl_if.slave        cpu
);

    irq_state_e         r_state, w_state_n;
    logic               r_take_int, w_take_int_n;
    logic               r_is_reset, w_is_reset_n;
    logic               r_is_nmi,   w_is_nmi_n;
    logic [2:0]         r_int_id,   w_int_id_n;
    logic               w_ack;
    logic               w_ack_nmi;
    logic               w_ack_irq;
    logic               w_nmi_latch;
    logic [NUM_IRQ-1:0] w_req;
    logic               w_any;
    logic [2:0]         w_sel;
    logic [15:0]        w_base;

    irq_edge_latch u_nmi_latch (
        .clk    (clk),
        .ce     (ce),
        .reset  (reset),
        .din    (nmi),
        .freeze (cpu.vec_fetch | r_is_reset),
        .clr    (w_ack_nmi),
        .latch  (w_nmi_latch)
    );

    for (genvar k = 0; k < NUM_IRQ; k++) begin : g_chan
        if (EDGE_MASK[k]) begin : g_edge
            irq_edge_latch u_latch (
                .clk    (clk),
                .ce     (ce),
                .reset  (reset),
                .din    (irq[k]),
                .freeze (1'b0),
                .clr    (w_ack_irq && (r_int_id == 3'(k))),
                .latch  (pending[k])
            );
        end else begin : g_level
            assign pending[k] = irq[k] & irq_en[k];
        end
    end

    assign w_req = pending & irq_en & {NUM_IRQ{~cpu.i_flag}};

    // Lowest index wins: scan from the top so the last hit is the smallest k.
    always_comb begin
        w_any = 1'b0;
        w_sel = 3'd0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (w_req[k]) begin
                w_any = 1'b1;
                w_sel = 3'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ARMED;
            r_take_int <= 1'b1;
            r_is_reset <= 1'b1;
            r_is_nmi   <= 1'b0;
            r_int_id   <= 3'd0;
        end else if (ce) begin
            r_state    <= w_state_n;
            r_take_int <= w_take_int_n;
            r_is_reset <= w_is_reset_n;
            r_is_nmi   <= w_is_nmi_n;
            r_int_id   <= w_int_id_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_take_int_n = r_take_int;
        w_is_reset_n = r_is_reset;
        w_is_nmi_n   = r_is_nmi;
        w_int_id_n   = r_int_id;
        w_ack        = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu.sample) begin
                    if (w_nmi_latch) begin
                        w_take_int_n = 1'b1;
                        w_is_nmi_n   = 1'b1;
                        w_state_n    = ARMED;
                    end else if (w_any) begin
                        w_take_int_n = 1'b1;
                        w_int_id_n   = w_sel;
                        w_state_n    = ARMED;
                    end
                end
            end
            ARMED: begin
                if (cpu.vec_fetch && !cpu.vec_hi) begin
                    w_state_n = LO_DONE;
                end
            end
            LO_DONE: begin
                if (cpu.vec_fetch && cpu.vec_hi) begin
                    w_ack        = 1'b1;
                    w_take_int_n = 1'b0;
                    w_is_reset_n = 1'b0;
                    w_is_nmi_n   = 1'b0;
                    w_state_n    = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    // The reset sequence owns no source, so its ack clears nothing.
    assign w_ack_nmi = w_ack & r_is_nmi & ~r_is_reset;
    assign w_ack_irq = w_ack & ~r_is_nmi & ~r_is_reset;

    always_comb begin
        w_base = VEC_IRQ;
        if (r_is_reset) begin
            w_base = VEC_RESET;
        end else if (r_is_nmi) begin
            w_base = VEC_NMI;
        end else if (VECTORED != 0) begin
            w_base = IRQ_TBL_BASE + {12'd0, r_int_id, 1'b0};
        end
    end

    assign cpu.vec_addr = w_base | {15'd0, cpu.vec_hi};
    assign cpu.take_int = r_take_int;
    assign cpu.is_reset = r_is_reset;
    assign cpu.is_nmi   = r_is_nmi;
    assign cpu.int_id   = r_int_id;

endmodule

`default_nettype wire

// File: tb/tb_irq_vector_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_irq_vector_ctrl
// Brief  : Directed self-checking bench; vectored and non-vectored instances.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_irq_vector_ctrl;

    logic       clk = 1'b0;
    logic       ce, reset, nmi;
    logic [3:0] irq, irq_en;
    logic       sample, vec_fetch, vec_hi, i_flag;
    logic [3:0] pending, pending_nv;
    int         n_checks = 0;
    int         n_fail   = 0;

    irq_vector_ctrl_if cpu ();
    irq_vector_ctrl_if cpu_nv ();

    assign cpu.sample       = sample;
    assign cpu.vec_fetch    = vec_fetch;
    assign cpu.vec_hi       = vec_hi;
    assign cpu.i_flag       = i_flag;
    assign cpu_nv.sample    = sample;
    assign cpu_nv.vec_fetch = vec_fetch;
    assign cpu_nv.vec_hi    = vec_hi;
    assign cpu_nv.i_flag    = i_flag;

    irq_vector_ctrl #(
        .NUM_IRQ(4), .EDGE_MASK(4'b0100), .VECTORED(1), .IRQ_TBL_BASE(16'hFFE0)
    ) u_dut (
        .clk(clk), .ce(ce), .reset(reset), .nmi(nmi), .irq(irq),
        .irq_en(irq_en), .pending(pending), .cpu(cpu)
    );

    irq_vector_ctrl #(
        .NUM_IRQ(4), .EDGE_MASK(4'b0100), .VECTORED(0), .IRQ_TBL_BASE(16'hFFE0)
    ) u_dut_nv (
        .clk(clk), .ce(ce), .reset(reset), .nmi(nmi), .irq(irq),
        .irq_en(irq_en), .pending(pending_nv), .cpu(cpu_nv)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        ce = 1'b1; reset = 1'b1; nmi = 1'b0; irq = 4'b0000; irq_en = 4'b1111;
        sample = 1'b0; vec_fetch = 1'b0; vec_hi = 1'b0; i_flag = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        // Reset sequence
        check("rst_take_int", 16'(cpu.take_int), 16'd1);
        check("rst_is_reset", 16'(cpu.is_reset), 16'd1);
        check("rst_is_nmi",   16'(cpu.is_nmi),   16'd0);
        check("rst_int_id",   16'(cpu.int_id),   16'd0);
        check("rst_vec_lo",   cpu.vec_addr,      16'hFFFC);
        check("rst_pending",  16'(pending),      16'd0);
        ce = 1'b0; vec_fetch = 1'b1; vec_hi = 1'b0;
        tick();
        ce = 1'b1; vec_hi = 1'b1;
        tick();
        check("ce_gate_hold", 16'(cpu.take_int), 16'd1);
        check("rst_vec_hi",   cpu.vec_addr,      16'hFFFD);
        vec_hi = 1'b0;
        tick();
        check("rst_lo_take",  16'(cpu.take_int), 16'd1);
        vec_hi = 1'b1;
        tick();
        check("rst_ack_take", 16'(cpu.take_int), 16'd0);
        check("rst_ack_isr",  16'(cpu.is_reset), 16'd0);
        vec_fetch = 1'b0; vec_hi = 1'b0;

        // NMI pulse then sample
        nmi = 1'b1;
        tick();
        nmi = 1'b0; sample = 1'b1;
        tick();
        check("nmi_take",     16'(cpu.take_int), 16'd1);
        check("nmi_is_nmi",   16'(cpu.is_nmi),   16'd1);
        sample = 1'b0; vec_fetch = 1'b1;
        tick();
        check("nmi_vec_lo",   cpu.vec_addr,      16'hFFFA);
        vec_hi = 1'b1;
        #1;
        check("nmi_vec_hi",   cpu.vec_addr,      16'hFFFB);
        tick();
        check("nmi_ack_take", 16'(cpu.take_int), 16'd0);
        check("nmi_ack_flag", 16'(cpu.is_nmi),   16'd0);
        vec_fetch = 1'b0; vec_hi = 1'b0; sample = 1'b1;
        tick();
        check("nmi_cleared",  16'(cpu.take_int), 16'd0);
        sample = 1'b0;

        // Vectored IRQ, two simultaneous requests: lowest index
        irq = 4'b0110;
        tick();
        check("irq_pending",  16'(pending),      16'h0006);
        sample = 1'b1;
        tick();
        check("irq_take",     16'(cpu.take_int), 16'd1);
        check("irq_id",       16'(cpu.int_id),   16'd1);
        check("irq_vec_lo",   cpu.vec_addr,      16'hFFE2);
        check("irq_nv_lo",    cpu_nv.vec_addr,   16'hFFFE);
        sample = 1'b0; vec_fetch = 1'b1;
        tick();
        vec_hi = 1'b1;
        #1;
        check("irq_vec_hi",   cpu.vec_addr,      16'hFFE3);
        check("irq_nv_hi",    cpu_nv.vec_addr,   16'hFFFF);
        tick();
        check("irq_ack_take", 16'(cpu.take_int), 16'd0);
        vec_fetch = 1'b0; vec_hi = 1'b0; irq = 4'b0000;
        tick();
        check("edge_sticky",  16'(pending),      16'h0004);

        // Edge channel 2 re-pulses during its own ack
        sample = 1'b1;
        tick();
        check("ch2_id",       16'(cpu.int_id),   16'd2);
        check("ch2_vec",      cpu.vec_addr,      16'hFFE4);
        sample = 1'b0; vec_fetch = 1'b1;
        tick();
        vec_hi = 1'b1; irq = 4'b0100;
        tick();
        check("ch2_ack_take", 16'(cpu.take_int), 16'd0);
        check("set_over_clr", 16'(pending),      16'h0004);
        vec_fetch = 1'b0; vec_hi = 1'b0; irq = 4'b0000; sample = 1'b1;
        tick();
        check("ch2_retake",   16'(cpu.take_int), 16'd1);
        check("ch2_re_id",    16'(cpu.int_id),   16'd2);
        sample = 1'b0; vec_fetch = 1'b1;
        tick();
        vec_hi = 1'b1;
        tick();
        check("ch2_cleared",  16'(pending),      16'h0000);
        check("ch2_re_ack",   16'(cpu.take_int), 16'd0);
        vec_fetch = 1'b0; vec_hi = 1'b0;

        // i_flag masks level IRQ, NMI still taken
        i_flag = 1'b1; irq = 4'b0001;
        tick();
        check("mask_pending", 16'(pending),      16'h0001);
        sample = 1'b1;
        tick();
        check("mask_take1",   16'(cpu.take_int), 16'd0);
        tick();
        check("mask_take2",   16'(cpu.take_int), 16'd0);
        sample = 1'b0; nmi = 1'b1;
        tick();
        nmi = 1'b0; sample = 1'b1;
        tick();
        check("mask_nmi",     16'(cpu.is_nmi),   16'd1);
        sample = 1'b0; vec_fetch = 1'b1;
        tick();
        vec_hi = 1'b1;
        tick();
        vec_fetch = 1'b0; vec_hi = 1'b0; i_flag = 1'b0; sample = 1'b1;
        tick();
        check("unmask_take",  16'(cpu.take_int), 16'd1);
        check("unmask_id",    16'(cpu.int_id),   16'd0);
        check("unmask_vec",   cpu.vec_addr,      16'hFFE0);
        sample = 1'b0; vec_fetch = 1'b1;
        tick();
        vec_hi = 1'b1;
        tick();
        vec_fetch = 1'b0; vec_hi = 1'b0;

        // NMI edge during an IRQ vector fetch is deferred
        sample = 1'b1;
        tick();
        check("defer_take",   16'(cpu.take_int), 16'd1);
        sample = 1'b0; irq = 4'b0000; vec_fetch = 1'b1; nmi = 1'b1;
        tick();
        vec_hi = 1'b1;
        tick();
        check("defer_ack",    16'(cpu.take_int), 16'd0);
        vec_fetch = 1'b0; vec_hi = 1'b0; sample = 1'b1;
        tick();
        check("defer_frozen", 16'(cpu.take_int), 16'd0);
        tick();
        check("defer_taken",  16'(cpu.take_int), 16'd1);
        check("defer_is_nmi", 16'(cpu.is_nmi),   16'd1);
        sample = 1'b0; vec_fetch = 1'b1;
        tick();
        vec_hi = 1'b1;
        tick();
        check("defer_done",   16'(cpu.take_int), 16'd0);
        vec_fetch = 1'b0; vec_hi = 1'b0; nmi = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
